dec_4x16_x_fault3: RTL and testbench

- Registered 4-to-16 one-hot decoder built from two 3-to-8 decoder slices.
- Bit X selects the slice; Y/Z/W select the line within the slice.
- Includes a built-in fault-injection model, "fault scenario 3": one configurable output line is forced to a stuck-at value while a runtime control is asserted.
- A fault-free golden decoder runs in parallel and flags disagreement, so the block can serve as a fault-detection target in decoder test infrastructure.

---
 rtl/dec_4x16_x_fault3_if.sv | 29 ++
 rtl/dec_4x16_x_fault3.sv | 64 ++++++
 tb/tb_dec_4x16_x_fault3.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dec_4x16_x_fault3_if.sv
//------------------------------------------------------------------------------
// dec_4x16_x_fault3_if : select/enable inputs and decoded/status outputs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dec_4x16_x_fault3_if;
  logic        X;
  logic        Y;
  logic        Z;
  logic        W;
  logic        en;
  logic        fault_en;
  logic [15:0] D;
  logic        mismatch;
  logic        onehot_err;

  modport master (
    output X, Y, Z, W, en, fault_en,
    input  D, mismatch, onehot_err
  );

  modport slave (
    input  X, Y, Z, W, en, fault_en,
    output D, mismatch, onehot_err
  );
endinterface

`default_nettype wire

// File: rtl/dec_4x16_x_fault3.sv
//------------------------------------------------------------------------------
// dec_4x16_x_fault3 : registered 4-to-16 decoder with stuck-at fault injection
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_4x16_x_fault3 #(
  parameter int FAULT_BIT = 3,
  parameter bit FAULT_VAL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  dec_4x16_x_fault3_if.slave     bus
);

  localparam logic [15:0] C_ZERO = 16'h0000;

  logic [15:0] golden;
  logic [15:0] faulted;
  logic [4:0]  ones;
  logic        onehot_next;

  // X picks which 3x8 slice is live; Y/Z/W pick the line inside it
  generate
    for (genvar s = 0; s < 2; s++) begin : g_slice
      logic slice_en;
      assign slice_en = bus.en & (bus.X == 1'(s));
      for (genvar j = 0; j < 8; j++) begin : g_line
        assign golden[s*8 + j] = slice_en & ({bus.Y, bus.Z, bus.W} == 3'(j));
      end
    end
  endgenerate

  always_comb begin
    faulted = golden;
    if (bus.fault_en) begin
      faulted[FAULT_BIT] = FAULT_VAL;
    end
  end

  always_comb begin
    ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + 5'(faulted[i]);
    end
  end

  assign onehot_next = bus.en ? (ones != 5'd1) : (faulted != C_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.D          <= C_ZERO;
      bus.mismatch   <= 1'b0;
      bus.onehot_err <= 1'b0;
    end else begin
      bus.D          <= faulted;
      bus.mismatch   <= (faulted != golden);
      bus.onehot_err <= onehot_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dec_4x16_x_fault3.sv
//------------------------------------------------------------------------------
// tb_dec_4x16_x_fault3 : table-driven check of the stuck-at-0 and stuck-at-1 builds
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dec_4x16_x_fault3;

  logic       clk;
  logic       rst;
  logic [3:0] sel;
  logic       en;
  logic       fen;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic        fen;
    logic [15:0] d;
    logic        mm;
    logic        oh;
  } vec_t;

  vec_t vecs[$];

  dec_4x16_x_fault3_if bus0 ();
  dec_4x16_x_fault3_if bus1 ();

  assign {bus0.X, bus0.Y, bus0.Z, bus0.W} = sel;
  assign bus0.en       = en;
  assign bus0.fault_en = fen;
  assign {bus1.X, bus1.Y, bus1.Z, bus1.W} = sel;
  assign bus1.en       = en;
  assign bus1.fault_en = fen;

  dec_4x16_x_fault3 #(.FAULT_BIT(3), .FAULT_VAL(1'b0)) u_sa0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dec_4x16_x_fault3 #(.FAULT_BIT(3), .FAULT_VAL(1'b1)) u_sa1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d0, input logic mm0, input logic oh0,
                           input logic [15:0] d1, input logic mm1, input logic oh1);
    check({tag, " sa0.D"},  32'(bus0.D),          32'(d0));
    check({tag, " sa0.mm"}, 32'(bus0.mismatch),   32'(mm0));
    check({tag, " sa0.oh"}, 32'(bus0.onehot_err), 32'(oh0));
    check({tag, " sa1.D"},  32'(bus1.D),          32'(d1));
    check({tag, " sa1.mm"}, 32'(bus1.mismatch),   32'(mm1));
    check({tag, " sa1.oh"}, 32'(bus1.onehot_err), 32'(oh1));
  endtask

  function automatic vec_t mk(input logic [3:0] s, input logic e, input logic f,
                              input logic [15:0] d, input logic m, input logic o);
    vec_t v;
    v.sel = s; v.en = e; v.fen = f; v.d = d; v.mm = m; v.oh = o;
    return v;
  endfunction

  logic [15:0] g1;
  logic [15:0] d1;

  initial begin
    total = 0;
    bad   = 0;

    // Expected values for the FAULT_VAL=0, FAULT_BIT=3 instance
    for (int i = 0; i < 16; i++) vecs.push_back(mk(4'(i), 1'b1, 1'b0, 16'h0001 << i, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  1'b1, 1'b1, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(4'd11, 1'b1, 1'b1, 16'h0800, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  1'b1, 1'b0, 16'h0008, 1'b0, 1'b0));
    vecs.push_back(mk(4'd0,  1'b1, 1'b1, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  1'b1, 1'b1, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(4'd3,  1'b1, 1'b0, 16'h0008, 1'b0, 1'b0));

    // Reset holds outputs low without any clock edge
    rst = 1'b1; sel = 4'd0; en = 1'b1; fen = 1'b0;
    #2;
    check_all("reset_async", 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_edge", 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("first_cap", 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      sel = vecs[k].sel; en = vecs[k].en; fen = vecs[k].fen;
      @(posedge clk); #1;
      // stuck-at-1 twin: golden plus a forced 1 on line 3
      g1 = vecs[k].en ? (16'h0001 << vecs[k].sel) : 16'h0000;
      d1 = vecs[k].fen ? (g1 | 16'h0008) : g1;
      check_all($sformatf("vec%0d", k), vecs[k].d, vecs[k].mm, vecs[k].oh,
                d1, (d1 != g1), (vecs[k].en ? ($countones(d1) != 1) : (d1 != 16'h0)));
    end

    // Stuck-at-1 hit on sel=0, then a mid-run reset clears at once
    sel = 4'd0; en = 1'b1; fen = 1'b1;
    @(posedge clk); #1;
    check_all("sa1_sel0", 16'h0001, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all("mid_reset", 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_over_edge", 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0; sel = 4'd9; fen = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset", 16'h0200, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
